id_ex_reg: RTL

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/id_ex_reg_pkg.sv | 35 +++
 rtl/pipe_field.sv | 29 ++
 rtl/id_ex_reg.sv | 134 +++++++++++++
 3 files changed

// File: rtl/id_ex_reg_pkg.sv
// Shared pipeline package: ALUOp encodings and the decoded control bundle.
// The ALU control stage imports the same definitions, so both sides agree on
// what each ALUOp value means.
//   alu_op_e   : 2-bit ALUOp (add, sub, R-type funct, and)
//   ctrl_t     : seven 1-bit control flags plus alu_op
//   ctrl_gate  : zero a control bundle unless the instruction is real
package id_ex_reg_pkg;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_AND   = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_to_reg;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    alu_src;
    logic    reg_dst;
    alu_op_e alu_op;
  } ctrl_t;

  localparam int unsigned BubbleCntWidth = 16;

  // An invalid slot must never write the register file or memory, so its
  // controls are forced to the all-zero bundle (which also means ALUOP_ADD).
  function automatic ctrl_t ctrl_gate(ctrl_t c, logic valid);
    return valid ? c : '0;
  endfunction

endpackage

// File: rtl/pipe_field.sv
// Width-parameterised pipeline field register.
//   clk : clock, rising edge
//   clr : synchronous clear to zero, dominates en
//   en  : load d into q
//   d   : next value
//   q   : registered value
module pipe_field #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] q_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      q_q <= '0;
    end else if (en) begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall, flush and a saturating bubble counter.
//   clk, rst_n        : clock and synchronous active-low reset
//   stall, flush      : hold all fields / load a bubble (flush wins)
//   id_*              : decoded instruction from the ID stage
//   ex_*              : registered copy presented to the EX stage
//   ex_func           : ex_imm[5:0], funct field for ALU control
//   bubble_count      : saturating count of flush edges
// Priority on each edge: reset > flush > stall > load.
module id_ex_reg
  import id_ex_reg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic        id_reg_write,
  input  logic        id_mem_to_reg,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        id_branch,
  input  logic        id_alu_src,
  input  logic        id_reg_dst,
  input  logic [1:0]  id_alu_op,
  input  logic [31:0] id_pc_plus4,
  input  logic [31:0] id_rd1,
  input  logic [31:0] id_rd2,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  output logic        ex_valid,
  output logic        ex_reg_write,
  output logic        ex_mem_to_reg,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_branch,
  output logic        ex_alu_src,
  output logic        ex_reg_dst,
  output logic [1:0]  ex_alu_op,
  output logic [31:0] ex_pc_plus4,
  output logic [31:0] ex_rd1,
  output logic [31:0] ex_rd2,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_rd,
  output logic [5:0]  ex_func,
  output logic [15:0] bubble_count
);

  localparam int unsigned CtrlFieldW = $bits(ctrl_t) + 1;
  localparam logic [BubbleCntWidth-1:0] BubbleMax = '1;

  // Reset and flush both zero every field; stall only suppresses the load.
  logic clr, en;
  assign clr = !rst_n || flush;
  assign en  = !stall;

  ctrl_t                  id_ctrl;
  ctrl_t                  ex_ctrl;
  logic [CtrlFieldW-1:0]  ctrl_field_d;
  logic [CtrlFieldW-1:0]  ctrl_field_q;

  assign id_ctrl = '{
    reg_write:  id_reg_write,
    mem_to_reg: id_mem_to_reg,
    mem_read:   id_mem_read,
    mem_write:  id_mem_write,
    branch:     id_branch,
    alu_src:    id_alu_src,
    reg_dst:    id_reg_dst,
    alu_op:     alu_op_e'(id_alu_op)
  };

  assign ctrl_field_d = {id_valid, ctrl_gate(id_ctrl, id_valid)};

  pipe_field #(.Width(CtrlFieldW)) u_ctrl (
    .clk (clk),
    .clr (clr),
    .en  (en),
    .d   (ctrl_field_d),
    .q   (ctrl_field_q)
  );

  assign {ex_valid, ex_ctrl} = ctrl_field_q;
  assign ex_reg_write  = ex_ctrl.reg_write;
  assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
  assign ex_mem_read   = ex_ctrl.mem_read;
  assign ex_mem_write  = ex_ctrl.mem_write;
  assign ex_branch     = ex_ctrl.branch;
  assign ex_alu_src    = ex_ctrl.alu_src;
  assign ex_reg_dst    = ex_ctrl.reg_dst;
  assign ex_alu_op     = ex_ctrl.alu_op;

  // Data fields are registered even for invalid slots; only controls are gated.
  pipe_field #(.Width(32)) u_pc_plus4 (
    .clk (clk), .clr (clr), .en (en), .d (id_pc_plus4), .q (ex_pc_plus4)
  );
  pipe_field #(.Width(32)) u_rd1 (
    .clk (clk), .clr (clr), .en (en), .d (id_rd1), .q (ex_rd1)
  );
  pipe_field #(.Width(32)) u_rd2 (
    .clk (clk), .clr (clr), .en (en), .d (id_rd2), .q (ex_rd2)
  );
  pipe_field #(.Width(32)) u_imm (
    .clk (clk), .clr (clr), .en (en), .d (id_imm), .q (ex_imm)
  );
  pipe_field #(.Width(5)) u_rs (
    .clk (clk), .clr (clr), .en (en), .d (id_rs), .q (ex_rs)
  );
  pipe_field #(.Width(5)) u_rt (
    .clk (clk), .clr (clr), .en (en), .d (id_rt), .q (ex_rt)
  );
  pipe_field #(.Width(5)) u_rd (
    .clk (clk), .clr (clr), .en (en), .d (id_rd), .q (ex_rd)
  );

  assign ex_func = ex_imm[5:0];

  logic [BubbleCntWidth-1:0] bubble_count_q;

  // Stall needs no term here: the counter only moves on flush or reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_count_q <= '0;
    end else if (flush && (bubble_count_q != BubbleMax)) begin
      bubble_count_q <= bubble_count_q + 1'b1;
    end
  end

  assign bubble_count = bubble_count_q;

endmodule
